threshold2_div_seq: RTL and testbench
=====================================

// Module: threshold2_div_seq
// PURPOSE
//  Sequential radix-2 restoring divider: inverse of the 20x8->28 unsigned pipelined multiplier in the threshold2 datapath.
//  Recovers a 20-bit value from a 28-bit product-domain sum and an 8-bit factor (e.g. mean = sum/count for threshold compute).
//  One quotient bit per cycle; valid/ready on both sides; global ce stall as for the multiplier cores.
// PARAMETERS
//  DVD_WIDTH  28  dividend width (bits)
//  DVS_WIDTH   8  divisor width; also remainder width
//  QUO_WIDTH  20  output quotient width; wider internal quotients saturate
// PORTS
//  clk        in   1          rising-edge clock
//  reset_n    in   1          asynchronous, active-low reset
//  ce         in   1          clock enable; 0 freezes all state and handshakes
//  in_valid   in   1          operands valid
//  in_ready   out  1          divider can accept operands
//  din0       in   DVD_WIDTH  dividend, unsigned
//  din1       in   DVS_WIDTH  divisor, unsigned
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  dout_q     out  QUO_WIDTH  quotient, saturated
//  dout_r     out  DVS_WIDTH  remainder
//  dbz        out  1          divide-by-zero flag, qualified by out_valid
//  ovf        out  1          quotient saturated, qualified by out_valid
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; dout_q=0; dout_r=0; dbz=0; ovf=0; bit counter=0.
//  Handshake rules:
//   - Transfer occurs only on an edge with ce=1 and valid&ready both high.
//   - in_ready is 1 only in IDLE.
//   - out_valid is 1 only in DONE.
//   - dout_*/dbz/ovf are held stable while out_valid=1 and out_ready=0.
//  States:
//   - IDLE -> CALC on input transfer; latch dividend and divisor; partial remainder=0; counter=DVD_WIDTH-1.
//   - IDLE -> DONE on input transfer with din1==0: dbz=1, dout_q=all ones, dout_r=0, ovf=0.
//   - CALC, each ce edge:
//     - rem' = {rem, dvd[cnt]}; if rem' >= dvs: rem' -= dvs, qbit=1.
//     - Shift qbit into the DVD_WIDTH-bit internal quotient; counter decrements.
//     - At counter==0 -> DONE.
//   - DONE -> IDLE on output transfer. No input is accepted in the same cycle; minimum initiation interval = DVD_WIDTH+2 cycles.
//  Latency: out_valid rises DVD_WIDTH ce-edges after the input-transfer edge, or 1 edge for divide-by-zero.
//  Width and saturation:
//   - Remainder arithmetic is DVS_WIDTH+1 bits wide.
//   - If internal quotient bits [DVD_WIDTH-1:QUO_WIDTH] are nonzero: dout_q=all ones, ovf=1.
//   - dout_r is always the true remainder.
//  Stall: ce=0 in any state holds state, counter and outputs; latency stretches by the stalled cycles.
//  Reset mid-CALC or mid-DONE: immediate return to the reset values; the in-flight result is discarded.
// CONFIGURATION
//  THRESHOLD2_DIV_ROUND_EN defined:
//   - Extra state ROUND between CALC and DONE, so latency = DVD_WIDTH+1.
//   - If 2*rem >= dvs, the quotient is incremented before the saturation check.
//   - dout_r still reports the truncating remainder.
//   - Divide-by-zero path is unchanged.
//  Not defined: truncating quotient; no ROUND state.
// STRUCTURE
//  Package threshold2_div_pkg:
//   - Default width localparams.
//   - State enum {IDLE, CALC, ROUND, DONE}.
//   - Function sat_q(): quotient saturation.
//  Sub-module threshold2_div_step: combinational single restoring step, ({rem, bit}, dvs) -> (rem', qbit).
//  Top module holds the FSM, counter, operand registers and output registers.
// TESTING
//  1. din0=1000, din1=7 -> dout_q=142, dout_r=6, dbz=0, ovf=0; out_valid rises exactly 28 edges after the accept edge.
//  2. din0=0xFFFFFFF, din1=255 -> dout_q=0xFFFFF, ovf=1, dout_r=15.
//  3. din0=12345, din1=0 -> out_valid 1 edge after accept; dbz=1, dout_q=0xFFFFF, dout_r=0.
//  4. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0; release -> IDLE with in_ready=1 one edge later.
//  5. ce=0 for 3 cycles mid-CALC -> same result, out_valid delayed by exactly 3 cycles.
//     Separately, pulse reset_n low mid-CALC -> all outputs return to reset values asynchronously.
//  6. With THRESHOLD2_DIV_ROUND_EN: 1000/7 -> dout_q=143, dout_r=6, latency 29.
//     Also 0xFFFFFFF/255 stays saturated with ovf=1.

Source files
------------

// File: rtl/threshold2_div_pkg.sv
// Shared widths, FSM state type and quotient saturation helper for the threshold2 divider.
package threshold2_div_pkg;
  localparam int DVD_W = 28;
  localparam int DVS_W = 8;
  localparam int QUO_W = 20;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  // Clamp an internal quotient to all ones when anything sits above bit qw-1.
  function automatic logic [63:0] sat_q(input logic [63:0] q, input int unsigned qw);
    if ((q >> qw) != 64'd0) return '1;
    return q;
  endfunction
endpackage

// File: rtl/threshold2_div_step.sv
// One restoring division step: shift in a dividend bit, subtract divisor if it fits.
module threshold2_div_step #(
  parameter int DVS_WIDTH = 8
) (
  input  logic [DVS_WIDTH-1:0] rem,
  input  logic                 bit_in,
  input  logic [DVS_WIDTH-1:0] dvs,
  output logic [DVS_WIDTH-1:0] rem_nx,
  output logic                 qbit
);
  logic [DVS_WIDTH:0] trial;
  logic [DVS_WIDTH:0] diff;

  assign trial  = {rem, bit_in};
  assign diff   = trial - {1'b0, dvs};
  assign qbit   = (trial >= {1'b0, dvs});
  assign rem_nx = qbit ? diff[DVS_WIDTH-1:0] : trial[DVS_WIDTH-1:0];
endmodule

// File: rtl/threshold2_div_seq.sv
// Sequential radix-2 restoring divider (dividend / 8-bit factor), one quotient bit per ce edge.
// Optional THRESHOLD2_DIV_ROUND_EN adds a ROUND state that rounds the quotient to nearest.
module threshold2_div_seq
  import threshold2_div_pkg::*;
#(
  parameter int DVD_WIDTH = DVD_W,
  parameter int DVS_WIDTH = DVS_W,
  parameter int QUO_WIDTH = QUO_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DVD_WIDTH-1:0] din0,
  input  logic [DVS_WIDTH-1:0] din1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUO_WIDTH-1:0] dout_q,
  output logic [DVS_WIDTH-1:0] dout_r,
  output logic                 dbz,
  output logic                 ovf
);
  localparam int CW = $clog2(DVD_WIDTH);

  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [DVD_WIDTH-1:0] dvd, quo, quo_nx, q_fin;
  logic [DVS_WIDTH-1:0] dvs, rem, rem_nx, r_fin;
  logic                 qbit, fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quo_nx    = {quo[DVD_WIDTH-2:0], qbit};

  threshold2_div_step #(.DVS_WIDTH(DVS_WIDTH)) u_step (
    .rem    (rem),
    .bit_in (dvd[cnt]),
    .dvs    (dvs),
    .rem_nx (rem_nx),
    .qbit   (qbit)
  );

`ifdef THRESHOLD2_DIV_ROUND_EN
  // Round half up: remainder at least half the divisor bumps the quotient.
  logic rnd_up;
  assign rnd_up = ({rem, 1'b0} >= {1'b0, dvs});
  assign q_fin  = quo + {{(DVD_WIDTH-1){1'b0}}, rnd_up};
  assign r_fin  = rem;
  assign fin    = (state == ROUND);
`else
  assign q_fin  = quo_nx;
  assign r_fin  = rem_nx;
  assign fin    = (state == CALC) && (cnt == '0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (in_valid) state_n = (din1 == '0) ? DONE : CALC;
`ifdef THRESHOLD2_DIV_ROUND_EN
      CALC:  if (cnt == '0) state_n = ROUND;
      ROUND: state_n = DONE;
`else
      CALC:  if (cnt == '0) state_n = DONE;
`endif
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (ce)  state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      dout_q <= '0;
      dout_r <= '0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
    end else if (ce) begin
      if (state == IDLE && in_valid) begin
        dvd <= din0;
        dvs <= din1;
        rem <= '0;
        quo <= '0;
        cnt <= CW'(DVD_WIDTH-1);
        dbz <= (din1 == '0);
        ovf <= 1'b0;
        if (din1 == '0) begin
          dout_q <= '1;
          dout_r <= '0;
        end
      end
      if (state == CALC) begin
        rem <= rem_nx;
        quo <= quo_nx;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (fin) begin
        dout_q <= QUO_WIDTH'(sat_q(64'(q_fin), QUO_WIDTH));
        dout_r <= r_fin;
        ovf    <= |q_fin[DVD_WIDTH-1:QUO_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_threshold2_div_seq.sv
// Directed bench for threshold2_div_seq: arithmetic reference model plus literal pins.
module tb_threshold2_div_seq;
  logic        clk, reset_n, ce, in_valid, in_ready, out_valid, out_ready, dbz, ovf;
  logic [27:0] din0;
  logic [7:0]  din1, dout_r;
  logic [19:0] dout_q;

  int n_cmp = 0, n_bad = 0;
  logic [19:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_z, exp_o;
  int          exp_lat;

  threshold2_div_seq dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout_q(dout_q), .dout_r(dout_r), .dbz(dbz), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division, optional round-half-up, clamp to 20 bits.
  // exp_lat counts ce edges up to out_valid, including the accepting edge.
  task automatic model(input logic [27:0] a, input logic [7:0] b);
    longint q, r;
    if (b == 0) begin
      exp_q = 20'hFFFFF; exp_r = 8'd0; exp_z = 1'b1; exp_o = 1'b0; exp_lat = 1;
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
`ifdef THRESHOLD2_DIV_ROUND_EN
      if (2 * r >= longint'(b)) q++;
      exp_lat = 30;
`else
      exp_lat = 29;
`endif
      exp_o = (q > 64'hFFFFF);
      exp_q = exp_o ? 20'hFFFFF : q[19:0];
      exp_r = r[7:0];
      exp_z = 1'b0;
    end
  endtask

  // Checks every presented result (including held back-pressure cycles) against the model.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      chk("mdl_q", 64'(dout_q), 64'(exp_q));
      chk("mdl_r", 64'(dout_r), 64'(exp_r));
      chk("mdl_dbz", 64'(dbz), 64'(exp_z));
      chk("mdl_ovf", 64'(ovf), 64'(exp_o));
    end
  end

  task automatic run(input logic [27:0] a, input logic [7:0] b, input int s_at, input int s_len,
                     input int bp, output logic [19:0] q, output logic [7:0] r,
                     output logic z, output logic o, output int n);
    model(a, b);
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    din0 = a; din1 = b; in_valid = 1'b1; out_ready = (bp == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      if (n == s_at) ce = 1'b0;
      if (n == s_at + s_len) ce = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ce = 1'b1;
    chk("latency", 64'(n), 64'(exp_lat + s_len));
    q = dout_q; r = dout_r; z = dbz; o = ovf;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_q", 64'(dout_q), 64'(q));
      chk("bp_hold_r", 64'(dout_r), 64'(r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
  endtask

  logic [19:0] q;
  logic [7:0]  r;
  logic        z, o;
  int          n;

  initial begin
    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(dout_q), 64'd0);
    chk("rst_r", 64'(dout_r), 64'd0);
    chk("rst_flags", 64'({dbz, ovf}), 64'd0);
    reset_n = 1'b1;

    run(28'd1000, 8'd7, -1, 0, 0, q, r, z, o, n);
`ifdef THRESHOLD2_DIV_ROUND_EN
    chk("lit_1000_7_q", 64'(q), 64'd143);
    chk("lit_1000_7_lat", 64'(n), 64'd30);
`else
    chk("lit_1000_7_q", 64'(q), 64'd142);
    chk("lit_1000_7_lat", 64'(n), 64'd29);
`endif
    chk("lit_1000_7_r", 64'(r), 64'd6);
    chk("lit_1000_7_flags", 64'({z, o}), 64'd0);

    run(28'hFFFFFFF, 8'd255, -1, 0, 0, q, r, z, o, n);
    chk("lit_max_q", 64'(q), 64'hFFFFF);
    chk("lit_max_r", 64'(r), 64'd15);
    chk("lit_max_ovf", 64'(o), 64'd1);

    // Async reset in the middle of a calculation
    @(negedge clk);
    din0 = 28'd5000; din1 = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_q", 64'(dout_q), 64'd0);
    chk("mid_rst_r", 64'(dout_r), 64'd0);
    chk("mid_rst_flags", 64'({dbz, ovf}), 64'd0);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", 64'({in_ready, out_valid}), 64'b10);

    run(28'd12345, 8'd0, -1, 0, 0, q, r, z, o, n);
    chk("lit_dbz_q", 64'(q), 64'hFFFFF);
    chk("lit_dbz_r", 64'(r), 64'd0);
    chk("lit_dbz_flags", 64'({z, o}), 64'b10);
    chk("lit_dbz_lat", 64'(n), 64'd1);

    run(28'd1000, 8'd7, -1, 0, 5, q, r, z, o, n);

    run(28'd1000, 8'd7, 10, 3, 0, q, r, z, o, n);
`ifdef THRESHOLD2_DIV_ROUND_EN
    chk("lit_stall_lat", 64'(n), 64'd33);
    chk("lit_stall_q", 64'(q), 64'd143);
`else
    chk("lit_stall_lat", 64'(n), 64'd32);
    chk("lit_stall_q", 64'(q), 64'd142);
`endif

    run(28'd0, 8'd5, -1, 0, 0, q, r, z, o, n);
    run(28'd5, 8'd9, -1, 0, 0, q, r, z, o, n);
    run(28'd10, 8'd4, -1, 0, 0, q, r, z, o, n);
    run(28'd209715000, 8'd200, -1, 0, 0, q, r, z, o, n);
    chk("lit_edge_q", 64'({q, o}), 64'({20'hFFFFF, 1'b0}));
    run(28'h0100000, 8'd1, -1, 0, 0, q, r, z, o, n);
    chk("lit_ovf1_q", 64'({q, o}), 64'({20'hFFFFF, 1'b1}));
    run(28'hFFFFFFF, 8'd1, -1, 0, 2, q, r, z, o, n);
    run(28'd27, 8'd9, -1, 0, 0, q, r, z, o, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
